// File: rtl/debounce_sync_if.sv
// Signal bundle for debounce_sync: raw level in, conditioned level and edge pulses out.
// The slave modport is the debouncer side; master is the consumer/driver side.
interface debounce_sync_if;
    logic data;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output data,
        input  q,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  data,
        output q,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stability-counting filter FSM that produces a clean
// level q plus registered one-cycle rise/fall pulses.
module debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH     = 8,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    debounce_sync_if.slave        sig
);

    if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_param_err
        $error("debounce_sync: STABLE_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
    end

    typedef enum logic [0:0] {StStable, StCheck} state_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntZero = '0;
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 q_q, q_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    // State register; reset wins over everything, which also suppresses a pending pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StStable;
            cnt_q   <= '0;
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            q_q     <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        sync1_d = sig.data;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;

        unique case (state_q)
            StStable: begin
                if (sync2_q == q_q) begin
                    cnt_d = CntZero;
                end else if (STABLE_CYCLES == 1) begin
                    q_d = sync2_q;
                end else begin
                    cnt_d   = CntOne;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // Any return to q discards the count so bounces never accumulate.
                if (sync2_q == q_q) begin
                    cnt_d   = CntZero;
                    state_d = StStable;
                end else if (cnt_q == CntLast) begin
                    q_d     = sync2_q;
                    cnt_d   = CntZero;
                    state_d = StStable;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                cnt_d   = CntZero;
                state_d = StStable;
            end
        endcase

        rise_d = ~q_q & q_d;
        fall_d = q_q & ~q_d;
    end

    always_comb begin
        sig.q    = q_q;
        sig.rise = rise_q;
        sig.fall = fall_q;
        sig.busy = (state_q == StCheck);
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync: one DUT with STABLE_CYCLES=4 and one with
// STABLE_CYCLES=1, outputs compared as {q, rise, fall, busy} after every edge.
module tb_debounce_sync;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    debounce_sync_if bus ();
    debounce_sync_if bus1 ();

    debounce_sync #(
        .STABLE_CYCLES (4),
        .CNT_WIDTH     (8),
        .RESET_LEVEL   (1'b0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .sig   (bus)
    );

    debounce_sync #(
        .STABLE_CYCLES (1),
        .CNT_WIDTH     (8),
        .RESET_LEVEL   (1'b0)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .sig   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic level);
        reset     = 1'b1;
        bus.data  = level;
        bus1.data = level;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        logic [3:0] act;
        reset     = 1'b1;
        bus.data  = 1'b1;
        bus1.data = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            act = {bus.q, bus.rise, bus.fall, bus.busy};
            exp = 4'b0000;
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL reset cycle %0d {q,rise,fall,busy}=%b expected %b", e, act, exp);
            end
        end
        reset = 1'b0;
        step();
        act = {bus.q, bus.rise, bus.fall, bus.busy};
        checks++;
        if (act !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release {q,rise,fall,busy}=%b expected 0000", act);
        end
    endtask

    task automatic test_clean_rise();
        logic [3:0] exp;
        logic [3:0] act;
        apply_reset(1'b0);
        bus.data = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp = {e >= 6, e == 6, 1'b0, e >= 3 && e <= 5};
            act = {bus.q, bus.rise, bus.fall, bus.busy};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL clean_rise edge %0d {q,rise,fall,busy}=%b expected %b", e, act, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        logic [3:0] act;
        apply_reset(1'b0);
        for (int e = 1; e <= 12; e++) begin
            bus.data = (e <= 3);
            step();
            // sync2 is high after edges 2..4, so the FSM is in CHECK after edges 3..5 only
            exp = {1'b0, 1'b0, 1'b0, e >= 3 && e <= 5};
            act = {bus.q, bus.rise, bus.fall, bus.busy};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL glitch edge %0d {q,rise,fall,busy}=%b expected %b", e, act, exp);
            end
        end
    endtask

    task automatic test_chatter();
        logic [2:0] act;
        apply_reset(1'b0);
        for (int e = 1; e <= 22; e++) begin
            bus.data = (e <= 16) && ((e % 4) != 0);
            step();
            act = {bus.q, bus.rise, bus.fall};
            checks++;
            if (act !== 3'b000) begin
                errors++;
                $display("FAIL chatter edge %0d {q,rise,fall}=%b expected 000", e, act);
            end
        end
    endtask

    task automatic test_clean_fall();
        logic [3:0] exp;
        logic [3:0] act;
        apply_reset(1'b0);
        bus.data = 1'b1;
        for (int e = 1; e <= 8; e++) step();
        checks++;
        if (bus.q !== 1'b1) begin
            errors++;
            $display("FAIL fall_setup q=%b expected 1", bus.q);
        end
        bus.data = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp = {e < 6, 1'b0, e == 6, e >= 3 && e <= 5};
            act = {bus.q, bus.rise, bus.fall, bus.busy};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL clean_fall edge %0d {q,rise,fall,busy}=%b expected %b", e, act, exp);
            end
        end
    endtask

    task automatic test_reset_mid_check();
        logic [3:0] exp;
        logic [3:0] act;
        apply_reset(1'b0);
        bus.data = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        act = {bus.q, bus.rise, bus.fall, bus.busy};
        checks++;
        if (act !== 4'b0000 || u_dut.cnt_q !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_check {q,rise,fall,busy}=%b cnt=%0d expected 0000 cnt=0",
                     act, u_dut.cnt_q);
        end
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            exp = {e >= 6, e == 6, 1'b0, e >= 3 && e <= 5};
            act = {bus.q, bus.rise, bus.fall, bus.busy};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL reset_mid_check edge %0d {q,rise,fall,busy}=%b expected %b",
                         e, act, exp);
            end
        end
    endtask

    task automatic test_reset_on_pulse();
        logic [3:0] act;
        apply_reset(1'b0);
        bus.data = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        reset = 1'b1;
        step();
        act = {bus.q, bus.rise, bus.fall, bus.busy};
        checks++;
        if (act !== 4'b0000) begin
            errors++;
            $display("FAIL reset_on_pulse {q,rise,fall,busy}=%b expected 0000", act);
        end
        reset = 1'b0;
    endtask

    task automatic test_min_filter();
        logic [3:0] exp;
        logic [3:0] act;
        apply_reset(1'b0);
        bus1.data = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            exp = {e >= 3, e == 3, 1'b0, 1'b0};
            act = {bus1.q, bus1.rise, bus1.fall, bus1.busy};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL min_filter edge %0d {q,rise,fall,busy}=%b expected %b", e, act, exp);
            end
        end
        bus1.data = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            exp = {e < 3, 1'b0, e == 3, 1'b0};
            act = {bus1.q, bus1.rise, bus1.fall, bus1.busy};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL min_filter_fall edge %0d {q,rise,fall,busy}=%b expected %b",
                         e, act, exp);
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        bus.data  = 1'b0;
        bus1.data = 1'b0;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_chatter();
        test_clean_fall();
        test_reset_mid_check();
        test_reset_on_pulse();
        test_min_filter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
